// File: rtl/sim_run_controller.sv
// sim_run_controller
//
// Sequences one simulation run of a DUT datapath: holds the DUT in reset for
// RESET_CYCLES cycles after a start request, enables it for a programmed number
// of cycles, waits for it to drain, then reports pass/fail and holds the result.
//
// Ports:
//   clk          sole clock, all state updates on posedge
//   reset        synchronous active-low reset
//   start        single-cycle run request, honoured in IDLE and DONE only
//   max_cycles   run length, sampled on an accepted start
//   dut_idle     DUT has no outstanding work
//   dut_error    DUT detected a fault
//   dut_reset    active-high reset to the DUT
//   run_en       DUT clock-enable / stimulus enable
//   cycle_count  RUN cycles elapsed in the current run
//   done         run finished, held until the next accepted start
//   pass         result, valid only while done is high
//   state        IDLE=0, RESET=1, RUN=2, DRAIN=3, DONE=4
//
// All outputs are registered; there is no combinational input-to-output path.

module sim_run_controller #(
  parameter int unsigned RESET_CYCLES  = 4,
  parameter int unsigned DRAIN_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] max_cycles,
  input  logic        dut_idle,
  input  logic        dut_error,
  output logic        dut_reset,
  output logic        run_en,
  output logic [31:0] cycle_count,
  output logic        done,
  output logic        pass,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StReset = 3'd1,
    StRun   = 3'd2,
    StDrain = 3'd3,
    StDone  = 3'd4
  } state_e;

  localparam logic [7:0]  RstLast   = 8'(RESET_CYCLES - 1);
  localparam logic [15:0] DrainLast = 16'(DRAIN_TIMEOUT - 1);

  state_e      state_q;
  logic [31:0] len_q;
  logic [7:0]  rst_cnt_q;
  logic [15:0] drain_cnt_q;
  logic        dut_reset_q;
  logic        run_en_q;
  logic [31:0] cycle_count_q;
  logic        done_q;
  logic        pass_q;

  // Count including the current RUN cycle; cannot wrap since it never exceeds len_q.
  logic [31:0] cnt_inc;
  assign cnt_inc = cycle_count_q + 32'd1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      len_q         <= '0;
      rst_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      dut_reset_q   <= 1'b1;
      run_en_q      <= 1'b0;
      cycle_count_q <= '0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_q       <= StReset;
            len_q         <= max_cycles;
            rst_cnt_q     <= '0;
            drain_cnt_q   <= '0;
            cycle_count_q <= '0;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            dut_reset_q   <= 1'b1;
            run_en_q      <= 1'b0;
          end
        end
        StReset: begin
          if (rst_cnt_q == RstLast) begin
            // dut_reset falls on the same edge run_en rises.
            dut_reset_q <= 1'b0;
            if (len_q == '0) begin
              state_q <= StDrain;
            end else begin
              state_q  <= StRun;
              run_en_q <= 1'b1;
            end
          end else begin
            rst_cnt_q <= rst_cnt_q + 8'd1;
          end
        end
        StRun: begin
          cycle_count_q <= cnt_inc;
          if (dut_error) begin
            state_q     <= StDone;
            run_en_q    <= 1'b0;
            dut_reset_q <= 1'b1;
            done_q      <= 1'b1;
            pass_q      <= 1'b0;
          end else if (cnt_inc == len_q) begin
            state_q  <= StDrain;
            run_en_q <= 1'b0;
          end
        end
        StDrain: begin
          // Error beats idle when both arrive together.
          if (dut_error || dut_idle || (drain_cnt_q == DrainLast)) begin
            state_q     <= StDone;
            dut_reset_q <= 1'b1;
            done_q      <= 1'b1;
            pass_q      <= !dut_error && dut_idle;
          end else begin
            drain_cnt_q <= drain_cnt_q + 16'd1;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign dut_reset   = dut_reset_q;
  assign run_en      = run_en_q;
  assign cycle_count = cycle_count_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign state       = state_q;

endmodule

// File: tb/tb_sim_run_controller.sv
// Self-checking bench for sim_run_controller. Each scenario's expected outcome
// (done edge, pass, final count, enable/reset cycle counts) is computed up front
// from the run's timeline rules, then compared against what the DUT shows.

module tb_sim_run_controller;

  localparam int R = 4;
  localparam int T = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] max_cycles;
  logic        dut_idle;
  logic        dut_error;
  logic        dut_reset;
  logic        run_en;
  logic [31:0] cycle_count;
  logic        done;
  logic        pass;
  logic [2:0]  state;

  int tests_run    = 0;
  int tests_failed = 0;

  sim_run_controller #(
    .RESET_CYCLES (R),
    .DRAIN_TIMEOUT(T)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .max_cycles (max_cycles),
    .dut_idle   (dut_idle),
    .dut_error  (dut_error),
    .dut_reset  (dut_reset),
    .run_en     (run_en),
    .cycle_count(cycle_count),
    .done       (done),
    .pass       (pass),
    .state      (state)
  );

  always #5 clk = ~clk;

  // Observations are indexed by e: outputs seen #1 after edge e, where edge 0
  // samples start. Inputs set after observation e are sampled at edge e+1.
  task automatic run_scenario(input string name, input int n, input int run_err,
                              input int drain_err, input int idle_j);
    int exp_done, exp_cc, exp_run, d_entry, first_err, first_idle, x;
    logic exp_pass;
    int run_cnt, rst_cnt, first_run, first_done;
    logic pass_at, last_done, last_rst;
    logic [31:0] cc_at;
    logic [2:0] st_at;

    d_entry = R + n;
    if (run_err > 0) begin
      exp_done = R + run_err;
      exp_pass = 1'b0;
      exp_cc   = run_err;
      exp_run  = run_err;
    end else begin
      exp_cc     = n;
      exp_run    = n;
      first_err  = (drain_err > 0) ? drain_err : 1000;
      first_idle = (idle_j > 0) ? idle_j : 1000;
      if (first_err <= first_idle && first_err <= T) begin
        exp_done = d_entry + first_err;
        exp_pass = 1'b0;
      end else if (first_idle <= T) begin
        exp_done = d_entry + first_idle;
        exp_pass = 1'b1;
      end else begin
        exp_done = d_entry + T;
        exp_pass = 1'b0;
      end
    end

    run_cnt = 0; rst_cnt = 0; first_run = -1; first_done = -1;
    pass_at = 1'bx; cc_at = 'x; st_at = 'x; last_done = 1'b0; last_rst = 1'b0;

    start      = 1'b1;
    max_cycles = 32'(n);
    dut_error  = 1'($urandom_range(0, 1));
    dut_idle   = 1'($urandom_range(0, 1));

    for (int e = 0; e <= exp_done + 2; e++) begin
      @(posedge clk);
      #1;
      if (e == 0) begin
        tests_run++;
        if (state !== 3'd1 || done !== 1'b0 || pass !== 1'b0 || cycle_count !== 32'd0 ||
            dut_reset !== 1'b1 || run_en !== 1'b0) begin
          tests_failed++;
          $display("FAIL %s start_accept: state=%0d done=%b pass=%b cc=%0d rst=%b en=%b, want 1 0 0 0 1 0",
                   name, state, done, pass, cycle_count, dut_reset, run_en);
        end
      end
      if (run_en === 1'b1) begin
        run_cnt++;
        if (first_run < 0) first_run = e;
      end
      if (e < exp_done && dut_reset === 1'b1) rst_cnt++;
      if (done === 1'b1 && first_done < 0) begin
        first_done = e;
        pass_at    = pass;
        cc_at      = cycle_count;
        st_at      = state;
      end
      last_done = done;
      last_rst  = dut_reset;

      x          = e + 1;
      start      = (x <= exp_done) ? ($urandom_range(0, 3) == 0) : 1'b0;
      max_cycles = $urandom;
      if (x <= R)             dut_error = 1'($urandom_range(0, 1));
      else if (x <= d_entry)  dut_error = (run_err > 0) && (x == R + run_err);
      else if (x <= exp_done) dut_error = (drain_err > 0) && (x == d_entry + drain_err);
      else                    dut_error = 1'($urandom_range(0, 1));
      if (x <= d_entry) dut_idle = 1'($urandom_range(0, 1));
      else              dut_idle = (idle_j > 0) && (x >= d_entry + idle_j);
    end
    start = 1'b0; dut_error = 1'b0; dut_idle = 1'b0;

    tests_run++;
    if (first_done !== exp_done) begin
      tests_failed++;
      $display("FAIL %s done_edge: got %0d want %0d", name, first_done, exp_done);
    end
    tests_run++;
    if (pass_at !== exp_pass) begin
      tests_failed++;
      $display("FAIL %s pass: got %b want %b", name, pass_at, exp_pass);
    end
    tests_run++;
    if (cc_at !== 32'(exp_cc)) begin
      tests_failed++;
      $display("FAIL %s cycle_count: got %0d want %0d", name, cc_at, exp_cc);
    end
    tests_run++;
    if (st_at !== 3'd4) begin
      tests_failed++;
      $display("FAIL %s done_state: got %0d want 4", name, st_at);
    end
    tests_run++;
    if (run_cnt !== exp_run) begin
      tests_failed++;
      $display("FAIL %s run_en_cycles: got %0d want %0d", name, run_cnt, exp_run);
    end
    tests_run++;
    if (rst_cnt !== R) begin
      tests_failed++;
      $display("FAIL %s dut_reset_cycles: got %0d want %0d", name, rst_cnt, R);
    end
    if (exp_run > 0) begin
      tests_run++;
      if (first_run !== R) begin
        tests_failed++;
        $display("FAIL %s first_run: got %0d want %0d", name, first_run, R);
      end
    end
    tests_run++;
    if (last_done !== 1'b1 || last_rst !== 1'b1) begin
      tests_failed++;
      $display("FAIL %s done_hold: done=%b dut_reset=%b want 1 1", name, last_done, last_rst);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; max_cycles = '0; dut_idle = 1'b0; dut_error = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests_run++;
    if (state !== 3'd0 || dut_reset !== 1'b1 || run_en !== 1'b0 || cycle_count !== 32'd0 ||
        done !== 1'b0 || pass !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_values: state=%0d rst=%b en=%b cc=%0d done=%b pass=%b, want 0 1 0 0 0 0",
               state, dut_reset, run_en, cycle_count, done, pass);
    end
    reset     = 1'b1;
    dut_error = 1'b1;
    @(posedge clk);
    #1;
    dut_error = 1'b0;
    tests_run++;
    if (state !== 3'd0 || dut_reset !== 1'b1 || done !== 1'b0) begin
      tests_failed++;
      $display("FAIL idle_hold: state=%0d rst=%b done=%b, want 0 1 0", state, dut_reset, done);
    end
  endtask

  task automatic test_midrun_reset();
    bit hit = 0;
    start = 1'b1; max_cycles = 32'hFFFF_FFFF; dut_error = 1'b0; dut_idle = 1'b1;
    for (int e = 0; e < R + 10 && !hit; e++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (state === 3'd2 && cycle_count === 32'd3) begin
        hit   = 1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        tests_run++;
        if (state !== 3'd0 || dut_reset !== 1'b1 || run_en !== 1'b0 ||
            cycle_count !== 32'd0 || done !== 1'b0 || pass !== 1'b0) begin
          tests_failed++;
          $display("FAIL midrun_reset: state=%0d rst=%b en=%b cc=%0d done=%b pass=%b, want 0 1 0 0 0 0",
                   state, dut_reset, run_en, cycle_count, done, pass);
        end
      end
    end
    tests_run++;
    if (!hit) begin
      tests_failed++;
      $display("FAIL midrun_reach: count 3 in RUN not seen, got state=%0d cc=%0d", state, cycle_count);
    end
    dut_idle = 1'b0;
    run_scenario("after_reset", 3, 0, 0, 2);
  endtask

  task automatic test_basic();
    run_scenario("basic", 10, 0, 0, 1);
  endtask

  task automatic test_zero_length();
    run_scenario("zero_len", 0, 0, 0, 1);
  endtask

  task automatic test_run_error();
    run_scenario("run_error", 8, 5, 0, 1);
    run_scenario("run_error_last", 3, 3, 0, 1);
  endtask

  task automatic test_timeout();
    run_scenario("timeout", 4, 0, 0, 0);
    run_scenario("idle_at_limit", 2, 0, 0, T);
    run_scenario("err_beats_idle", 2, 0, 3, 3);
  endtask

  task automatic test_back_to_back();
    run_scenario("back_to_back", 2, 0, 0, 1);
  endtask

  task automatic test_random();
    int n, mode, k, j1, j2;
    for (int i = 0; i < 25; i++) begin
      n    = $urandom_range(0, 12);
      mode = $urandom_range(0, 3);
      k = 0; j1 = 0; j2 = 0;
      case (mode)
        0: begin
          if (n > 0) k = $urandom_range(1, n);
          else j2 = 1;
        end
        1: j2 = $urandom_range(1, 20);
        2: begin
          j1 = $urandom_range(1, 18);
          j2 = $urandom_range(1, 18);
        end
        default: ;
      endcase
      run_scenario($sformatf("rand%0d", i), n, k, j1, j2);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero_length();
    test_run_error();
    test_timeout();
    test_back_to_back();
    test_midrun_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/sim_run_controller.md
# sim_run_controller

Sequences one simulation run of the DUT datapath: holds the DUT in reset for a fixed number of cycles, enables it for a programmed number of cycles, waits for it to drain, then reports pass or fail. Sits between the testbench top and the DUT and replaces ad-hoc counter/`$finish` end-of-test logic with a single registered state machine. The testbench acts on `done` and `pass` to end the simulation.

## Interface
Parameters:
- `RESET_CYCLES`, default 4: cycles `dut_reset` is held after `start`; legal range 1..255.
- `DRAIN_TIMEOUT`, default 16: maximum DRAIN cycles spent waiting for `dut_idle`; legal range 1..65535.

Ports (one clock; reset is synchronous and active-low):
- `clk`  in  1  sole clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-low; low at a posedge forces reset values.
- `start`  in  1  single-cycle run request; honoured in IDLE and DONE only.
- `max_cycles`  in  32  run length; sampled only on an accepted `start`.
- `dut_idle`  in  1  DUT has no outstanding work.
- `dut_error`  in  1  DUT detected a fault.
- `dut_reset`  out  1  active-high reset to the DUT.
- `run_en`  out  1  DUT clock-enable / stimulus enable.
- `cycle_count`  out  32  RUN cycles elapsed in the current run.
- `done`  out  1  run finished; held until the next accepted `start`.
- `pass`  out  1  result; valid only while `done`=1.
- `state`  out  3  IDLE=0, RESET=1, RUN=2, DRAIN=3, DONE=4.

## Operation
- Reset values: `state`=IDLE, `dut_reset`=1, `run_en`=0, `cycle_count`=0, `done`=0, `pass`=0; internal latched length and timers are cleared to 0.
- IDLE: `dut_reset`=1. `start`=1 latches `max_cycles` -> RESET, clears `cycle_count`.
- RESET: `dut_reset`=1 for exactly `RESET_CYCLES` cycles -> RUN, or -> DRAIN directly if the latched length is 0.
- RUN: `dut_reset`=0, `run_en`=1, `cycle_count` +1 per cycle. After exactly the latched length of cycles -> DRAIN with `cycle_count` equal to that length. `dut_error`=1 in any RUN cycle -> DONE with `pass`=0; `cycle_count` freezes, including the count of that cycle.
- DRAIN: `run_en`=0, `dut_reset`=0. `dut_idle`=1 -> DONE with `pass`=1. `dut_error`=1 -> DONE with `pass`=0; if `dut_error` and `dut_idle` are high in the same cycle, error wins. After `DRAIN_TIMEOUT` cycles without idle -> DONE with `pass`=0.
- DONE: `done`=1, `dut_reset`=1, `run_en`=0, and `pass`/`cycle_count` are held. `start` -> RESET and clears `done`, `pass` and `cycle_count`.
- `start` is ignored in RESET, RUN and DRAIN. `dut_error` is ignored in IDLE, RESET and DONE.
- `cycle_count` never wraps because it cannot exceed the latched 32-bit length. `max_cycles`=32'hFFFF_FFFF is legal.
- `reset` low in any state returns all outputs to reset values at that edge; there is no partial-run memory.

## Timing
- All outputs are registered; there is no combinational input-to-output path.
- `start` sampled at edge t:
  - `state`=RESET from t+1.
  - First RUN cycle at t+1+`RESET_CYCLES`.
  - `dut_reset` falls at the same edge that `run_en` rises.
- For N=`max_cycles`>0, `run_en` is high for exactly N consecutive cycles.
- `dut_idle` high in the first DRAIN cycle gives `done`=1 on the next cycle, so minimum DRAIN residency is 1 cycle.
- Timeout: DONE is entered `DRAIN_TIMEOUT` cycles after DRAIN entry.
- An error in RUN or DRAIN at edge e gives `done`=1 at e+1.

## Test plan
- `reset` low 3 cycles, then `start` with `max_cycles`=10 and `dut_idle`=1 -> 4 cycles `dut_reset`, 10 cycles `run_en`, 1 DRAIN cycle, then `done`=1, `pass`=1, `cycle_count`=10.
- `max_cycles`=0 with `dut_idle`=1 -> RESET -> DRAIN -> DONE; `run_en` never high; `pass`=1, `cycle_count`=0.
- `max_cycles`=8 with `dut_error` pulsed on RUN cycle 5 -> `done`=1 next cycle, `pass`=0, `cycle_count`=5; no DRAIN.
- `dut_idle` held 0 -> DONE exactly 16 cycles after DRAIN entry, `pass`=0; a second `start` pulse during DRAIN is ignored.
- `reset` driven low mid-RUN (`cycle_count`=3) -> next edge shows all reset values and `state`=0; a new `start` then runs cleanly.
- Back-to-back: `start` in DONE with new `max_cycles`=2 -> `done`/`pass` clear at t+1 and the new run has `run_en` high for 2 cycles.
